vx_commit_arb: RTL and testbench

Writeback-side commit arbiter for one issue slot. It merges the commit streams produced by the execute units (ALU, LSU, SFU, FPU, tensor) into a single writeback stream toward the register file and scoreboard release. Arbitration is packet-aware: a multi-beat commit (sop..eop) is never interleaved with another unit. A 2-entry elastic buffer decouples the unit handshakes from writeback back-pressure. One instance exists per issue slot.

---
 rtl/vx_commit_arb.sv | 166 ++++++++++++++++
 tb/tb_vx_commit_arb.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/vx_commit_arb.sv
// Purpose: merges NUM_SRCS execute-unit commit streams into one packet-aware writeback stream.
// Latency: 1 cycle from source accept to wb_valid_o; 1 beat/cycle sustained with wb_ready_i=1.
// Backpressure: a 2-entry elastic buffer absorbs writeback stalls; src_ready_o drops when it is full.
//
// Ports:
//   clk_i, reset_i (async, active-low)
//   src_valid_i/src_data_i/src_eop_i/src_ready_o : per-unit commit beats (unit i at [i*DATA_WIDTH +: DATA_WIDTH])
//   wb_valid_o/wb_data_o/wb_eop_o/wb_ready_i     : merged writeback stream
//   perf_stalls_o                                : cycles with a valid source but no accepted beat
module vx_commit_arb #(
  parameter int NUM_SRCS   = 4,
  parameter int DATA_WIDTH = 64
) (
  input  logic                           clk_i,
  input  logic                           reset_i,
  input  logic [NUM_SRCS-1:0]            src_valid_i,
  input  logic [NUM_SRCS*DATA_WIDTH-1:0] src_data_i,
  input  logic [NUM_SRCS-1:0]            src_eop_i,
  output logic [NUM_SRCS-1:0]            src_ready_o,
  output logic                           wb_valid_o,
  output logic [DATA_WIDTH-1:0]          wb_data_o,
  output logic                           wb_eop_o,
  input  logic                           wb_ready_i,
  output logic [31:0]                    perf_stalls_o
);

  localparam int IW = (NUM_SRCS > 1) ? $clog2(NUM_SRCS) : 1;

  typedef enum logic {IDLE, LOCKED} state_e;

  state_e                state_q, state_d;
  logic [IW-1:0]         lock_idx_q, lock_idx_d;
  logic [IW-1:0]         rr_ptr_q, rr_ptr_d;
  logic [1:0]            count_q, count_d;
  logic [DATA_WIDTH-1:0] head_dat_q, head_dat_d, tail_dat_q, tail_dat_d;
  logic                  head_eop_q, head_eop_d, tail_eop_q, tail_eop_d;
  logic [31:0]           stalls_q, stalls_d;

  logic [NUM_SRCS-1:0]   grant;
  logic [IW-1:0]         win_idx;
  logic [DATA_WIDTH-1:0] win_dat;
  logic                  win_eop;
  logic                  accept;
  logic                  pop;

  // Unlocked: first valid source scanning upward from rr_ptr+1 (wrapping).
  // Locked: the packet owner keeps the grant even while it is not valid.
  always_comb begin
    int   idx;
    logic found;
    grant   = '0;
    win_idx = '0;
    found   = 1'b0;
    idx     = 0;
    if (state_q == LOCKED) begin
      grant[lock_idx_q] = 1'b1;
      win_idx           = lock_idx_q;
    end else begin
      for (int k = 1; k <= NUM_SRCS; k++) begin
        idx = int'(rr_ptr_q) + k;
        if (idx >= NUM_SRCS) idx = idx - NUM_SRCS;
        if (!found && src_valid_i[IW'(idx)]) begin
          found            = 1'b1;
          grant[IW'(idx)]  = 1'b1;
          win_idx          = IW'(idx);
        end
      end
    end
  end

  assign src_ready_o = grant & src_valid_i
                     & {NUM_SRCS{count_q != 2'd2}}
                     & {NUM_SRCS{reset_i}};
  assign accept      = |src_ready_o;
  assign pop         = (count_q != 2'd0) && wb_ready_i;

  always_comb begin
    win_dat = '0;
    win_eop = 1'b0;
    for (int i = 0; i < NUM_SRCS; i++) begin
      if (win_idx == IW'(i)) begin
        win_dat = src_data_i[i*DATA_WIDTH +: DATA_WIDTH];
        win_eop = src_eop_i[i];
      end
    end
  end

  // Lock FSM, round-robin pointer and stall counter.
  always_comb begin
    state_d    = state_q;
    lock_idx_d = lock_idx_q;
    rr_ptr_d   = rr_ptr_q;
    stalls_d   = stalls_q;
    if (accept) begin
      if (win_eop) begin
        state_d  = IDLE;
        rr_ptr_d = win_idx;
      end else begin
        state_d    = LOCKED;
        lock_idx_d = win_idx;
      end
    end else if (|src_valid_i) begin
      stalls_d = stalls_q + 32'd1;
    end
  end

  // Elastic buffer as head/tail registers; the head drives the writeback
  // outputs directly so they are register outputs.
  always_comb begin
    count_d    = count_q;
    head_dat_d = head_dat_q;
    head_eop_d = head_eop_q;
    tail_dat_d = tail_dat_q;
    tail_eop_d = tail_eop_q;
    if (accept && pop) begin
      // Only reachable at count 1: the new beat becomes the head.
      head_dat_d = win_dat;
      head_eop_d = win_eop;
    end else if (accept) begin
      count_d = count_q + 2'd1;
      if (count_q == 2'd0) begin
        head_dat_d = win_dat;
        head_eop_d = win_eop;
      end else begin
        tail_dat_d = win_dat;
        tail_eop_d = win_eop;
      end
    end else if (pop) begin
      count_d = count_q - 2'd1;
      if (count_q == 2'd2) begin
        head_dat_d = tail_dat_q;
        head_eop_d = tail_eop_q;
      end
    end
  end

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      state_q    <= IDLE;
      lock_idx_q <= '0;
      rr_ptr_q   <= IW'(NUM_SRCS - 1);
      count_q    <= 2'd0;
      head_dat_q <= '0;
      head_eop_q <= 1'b0;
      tail_dat_q <= '0;
      tail_eop_q <= 1'b0;
      stalls_q   <= 32'd0;
    end else begin
      state_q    <= state_d;
      lock_idx_q <= lock_idx_d;
      rr_ptr_q   <= rr_ptr_d;
      count_q    <= count_d;
      head_dat_q <= head_dat_d;
      head_eop_q <= head_eop_d;
      tail_dat_q <= tail_dat_d;
      tail_eop_q <= tail_eop_d;
      stalls_q   <= stalls_d;
    end
  end

  assign wb_valid_o    = (count_q != 2'd0);
  assign wb_data_o     = head_dat_q;
  assign wb_eop_o      = head_eop_q;
  assign perf_stalls_o = stalls_q;

endmodule

// File: tb/tb_vx_commit_arb.sv
module tb_vx_commit_arb;

  localparam int N  = 4;
  localparam int DW = 64;

  logic            clk;
  logic            rst_n;
  logic [N-1:0]    src_valid;
  logic [N*DW-1:0] src_data;
  logic [N-1:0]    src_eop;
  logic [N-1:0]    src_ready;
  logic            wb_valid;
  logic [DW-1:0]   wb_data;
  logic            wb_eop;
  logic            wb_ready;
  logic [31:0]     perf_stalls;

  logic [DW-1:0]   sdat [N];

  vx_commit_arb #(.NUM_SRCS(N), .DATA_WIDTH(DW)) dut (
    .clk_i         (clk),
    .reset_i       (rst_n),
    .src_valid_i   (src_valid),
    .src_data_i    (src_data),
    .src_eop_i     (src_eop),
    .src_ready_o   (src_ready),
    .wb_valid_o    (wb_valid),
    .wb_data_o     (wb_data),
    .wb_eop_o      (wb_eop),
    .wb_ready_i    (wb_ready),
    .perf_stalls_o (perf_stalls)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    src_data = '0;
    for (int i = 0; i < N; i++) src_data[i*DW +: DW] = sdat[i];
  end

  // Behavioural model: packet lock, round-robin pointer, FIFO queue, stall count.
  typedef struct packed {
    logic          eop;
    logic [DW-1:0] dat;
  } beat_t;

  beat_t       m_q [$];
  bit          m_locked;
  int          m_lock;
  int          m_rr;
  int unsigned m_stalls;

  logic [DW-1:0] wb_log [$];

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_locked = 1'b0;
    m_lock   = 0;
    m_rr     = N - 1;
    m_stalls = 0;
  endtask

  // One clock: compare DUT against the model on the falling edge, then
  // advance the model with the same inputs at the rising edge.
  task automatic step();
    int           g;
    logic [N-1:0] exp_rdy;
    @(negedge clk);
    g = -1;
    if (m_locked) g = m_lock;
    else begin
      for (int k = 1; k <= N; k++) begin
        if (g < 0 && src_valid[(m_rr + k) % N]) g = (m_rr + k) % N;
      end
    end
    exp_rdy = '0;
    if (rst_n && g >= 0 && src_valid[g] && m_q.size() < 2) exp_rdy[g] = 1'b1;
    chk("src_ready", 64'(src_ready), 64'(exp_rdy));
    chk("wb_valid", 64'(wb_valid), 64'(m_q.size() != 0));
    if (m_q.size() != 0) begin
      chk("wb_data", wb_data, m_q[0].dat);
      chk("wb_eop", 64'(wb_eop), 64'(m_q[0].eop));
    end
    chk("perf_stalls", 64'(perf_stalls), 64'(m_stalls));
    if (wb_valid && wb_ready) wb_log.push_back(wb_data);
    @(posedge clk);
    if (rst_n) begin
      if (m_q.size() != 0 && wb_ready) void'(m_q.pop_front());
      if (exp_rdy != '0) begin
        m_q.push_back({src_eop[g], sdat[g]});
        if (src_eop[g]) begin
          m_locked = 1'b0;
          m_rr     = g;
        end else begin
          m_locked = 1'b1;
          m_lock   = g;
        end
      end else if (|src_valid) begin
        m_stalls++;
      end
    end
    #1;
  endtask

  task automatic set_src(input int i, input logic v, input logic e, input logic [DW-1:0] d);
    src_valid[i] = v;
    src_eop[i]   = e;
    sdat[i]      = d;
  endtask

  initial begin
    int          base;
    int unsigned p0;
    logic [DW-1:0] exp_rr [8];
    logic [DW-1:0] exp_lk [6];
    logic [DW-1:0] exp_sv [3];

    // ---- reset then idle ----
    rst_n    = 1'b0;
    wb_ready = 1'b1;
    for (int i = 0; i < N; i++) set_src(i, 1'b1, 1'b1, DW'(64'h100 + i));
    model_reset();
    #1;
    chk("rst_src_ready", 64'(src_ready), 64'd0);
    chk("rst_wb_valid", 64'(wb_valid), 64'd0);
    chk("rst_wb_data", wb_data, 64'd0);
    chk("rst_wb_eop", 64'(wb_eop), 64'd0);
    chk("rst_perf", 64'(perf_stalls), 64'd0);
    step();
    step();
    rst_n = 1'b1;
    src_valid = '0;
    repeat (10) step();
    chk("idle_perf", 64'(perf_stalls), 64'd0);
    chk("idle_wb_valid", 64'(wb_valid), 64'd0);

    // ---- round robin, single-beat packets ----
    base = wb_log.size();
    for (int i = 0; i < N; i++) set_src(i, 1'b1, 1'b1, DW'(64'h100 + i));
    chk("rr_pre_valid", 64'(wb_valid), 64'd0);
    step();
    chk("rr_lat_valid", 64'(wb_valid), 64'd1);
    chk("rr_lat_data", wb_data, 64'h100);
    repeat (7) step();
    src_valid = '0;
    repeat (2) step();
    exp_rr = '{64'h100, 64'h101, 64'h102, 64'h103, 64'h100, 64'h101, 64'h102, 64'h103};
    for (int i = 0; i < 8; i++) chk("rr_order", wb_log[base + i], exp_rr[i]);

    // ---- packet lock ----
    base = wb_log.size();
    set_src(0, 1'b1, 1'b1, 64'h100);
    step();
    set_src(2, 1'b1, 1'b1, 64'h102);
    set_src(1, 1'b1, 1'b0, 64'h211);
    p0 = perf_stalls;
    step();
    set_src(1, 1'b1, 1'b0, 64'h212);
    step();
    set_src(1, 1'b1, 1'b1, 64'h213);
    step();
    chk("lock_perf", 64'(perf_stalls), 64'(p0));
    set_src(1, 1'b0, 1'b0, 64'h0);
    step();
    set_src(2, 1'b0, 1'b0, 64'h0);
    step();
    src_valid = '0;
    repeat (2) step();
    exp_lk = '{64'h100, 64'h211, 64'h212, 64'h213, 64'h102, 64'h100};
    for (int i = 0; i < 6; i++) chk("lock_order", wb_log[base + i], exp_lk[i]);

    // ---- back-pressure ----
    wb_ready = 1'b0;
    set_src(0, 1'b1, 1'b1, 64'h100);
    p0 = perf_stalls;
    repeat (5) step();
    chk("bp_perf", 64'(perf_stalls - p0), 64'd3);
    chk("bp_ready_low", 64'(src_ready), 64'd0);
    wb_ready = 1'b1;
    step();
    chk("bp_ready_back", 64'(src_ready), 64'b0001);
    step();
    src_valid = '0;
    repeat (3) step();

    // ---- locked starvation ----
    base = wb_log.size();
    set_src(0, 1'b1, 1'b1, 64'h100);
    set_src(3, 1'b1, 1'b0, 64'h3a1);
    step();
    set_src(3, 1'b0, 1'b0, 64'h0);
    p0 = perf_stalls;
    repeat (4) step();
    chk("starve_perf", 64'(perf_stalls - p0), 64'd4);
    set_src(3, 1'b1, 1'b1, 64'h3a2);
    step();
    set_src(3, 1'b0, 1'b0, 64'h0);
    step();
    src_valid = '0;
    repeat (2) step();
    exp_sv = '{64'h3a1, 64'h3a2, 64'h100};
    for (int i = 0; i < 3; i++) chk("starve_order", wb_log[base + i], exp_sv[i]);

    // ---- async reset mid-packet with two buffered beats ----
    wb_ready = 1'b0;
    set_src(1, 1'b1, 1'b0, 64'h211);
    step();
    set_src(1, 1'b1, 1'b0, 64'h212);
    step();
    set_src(1, 1'b1, 1'b1, 64'h213);
    chk("pre_rst_valid", 64'(wb_valid), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_wb_valid", 64'(wb_valid), 64'd0);
    chk("arst_src_ready", 64'(src_ready), 64'd0);
    model_reset();
    step();
    #2;
    rst_n    = 1'b1;
    wb_ready = 1'b1;
    set_src(0, 1'b1, 1'b1, 64'h100);
    set_src(1, 1'b1, 1'b1, 64'h101);
    #1;
    chk("post_rst_grant", 64'(src_ready), 64'b0001);
    step();
    step();
    src_valid = '0;
    repeat (2) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
